// File: rtl/instr_encoder.sv
// RV32 field-to-word encoder with a DEPTH-entry output FIFO and per-word address tagging.
// Optional saturating unknown-opcode counter on err_cnt when ENC_ERR_CNT_EN is defined.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [31:0] imm,
  input  logic [6:0]  func7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_unknown,
`ifdef ENC_ERR_CNT_EN
  output logic        err_misalign,
  output logic [15:0] err_cnt
);
`else
  output logic        err_misalign
);
`endif

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
  } fmt_e;

  fmt_e        w_fmt;
  logic        w_shift;
  logic [31:0] w_word;
  logic        w_known;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;

  logic [31:0] r_mem_instr [DEPTH];
  logic [31:0] r_mem_addr  [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_addr;
  logic          r_err_unknown;
  logic          r_err_misalign;

  always_comb begin
    w_fmt = FMT_X;
    case (opcode)
      7'b0110011, 7'b0101111:                         w_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
      7'b0100011:                                     w_fmt = FMT_S;
      7'b1100011:                                     w_fmt = FMT_B;
      7'b1101111:                                     w_fmt = FMT_J;
      7'b0010111, 7'b0110111:                         w_fmt = FMT_U;
      default:                                        w_fmt = FMT_X;
    endcase
  end

  // Shift-immediates carry the shamt in imm[4:0] and the funct7 bits separately.
  assign w_shift = (opcode == 7'b0010011) && ((func3 == 3'd1) || (func3 == 3'd5));

  always_comb begin
    w_word = '0;
    case (w_fmt)
      FMT_R: w_word = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I: w_word = w_shift ? {func7, imm[4:0], rs1, func3, rd, opcode}
                              : {imm[11:0], rs1, func3, rd, opcode};
      FMT_S: w_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B: w_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      FMT_U: w_word = {imm[31:12], rd, opcode};
      FMT_J: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_word = '0;
    endcase
  end

  assign w_known   = (w_fmt != FMT_X);
  assign w_full    = (r_count == CNT_FULL);
  assign in_ready  = !w_full && !flush;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_known;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready && !flush;

  // NOTE: storage is left unreset; the outputs are masked to zero whenever the FIFO is empty,
  // so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wptr] <= w_word;
      r_mem_addr[r_wptr]  <= r_addr;
    end
  end

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_addr         <= BASE_ADDR;
      r_err_unknown  <= 1'b0;
      r_err_misalign <= 1'b0;
    end else if (flush) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_addr         <= BASE_ADDR;
      r_err_unknown  <= 1'b0;
      r_err_misalign <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
        r_addr <= r_addr + 32'd4;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
      r_err_unknown  <= w_accept && !w_known;
      r_err_misalign <= w_push && ((w_fmt == FMT_B) || (w_fmt == FMT_J)) && imm[0];
    end
  end

  assign out_instr    = out_valid ? r_mem_instr[r_rptr] : '0;
  assign out_addr     = out_valid ? r_mem_addr[r_rptr]  : '0;
  assign err_unknown  = r_err_unknown;
  assign err_misalign = r_err_misalign;

`ifdef ENC_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (flush) begin
      r_err_cnt <= '0;
    end else if (w_accept && !w_known && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
